// File: rtl/mult_types.sv
// Shared widths, op/state enums and multiplier signedness codes for the RV32M multiply
// issue stage.
package mult_types;

  localparam int unsigned width_p = 32;

  typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU} mul_op_e;

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, RESP, ABORT} mic_state_e;

  localparam logic [2:0] MCODE_LO = 3'b000;
  localparam logic [2:0] MCODE_SS = 3'b001;
  localparam logic [2:0] MCODE_SU = 3'b011;
  localparam logic [2:0] MCODE_UU = 3'b010;

  function automatic mul_op_e decode_op(input logic [2:0] funct3);
    case (funct3)
      3'b001:  return OP_MULH;
      3'b010:  return OP_MULHSU;
      3'b011:  return OP_MULHU;
      default: return OP_MUL;
    endcase
  endfunction

  function automatic logic [2:0] op_code(input mul_op_e op);
    unique case (op)
      OP_MULH:   return MCODE_SS;
      OP_MULHSU: return MCODE_SU;
      OP_MULHU:  return MCODE_UU;
      default:   return MCODE_LO;
    endcase
  endfunction

  function automatic logic [width_p-1:0] sel_half(input logic [2*width_p-1:0] product,
                                                  input logic                 lo);
    return lo ? product[width_p-1:0] : product[2*width_p-1:width_p];
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_cache.sv
// One-entry product cache: stores the last full product tagged by operands and signedness
// code, and returns the requested half on a hit.
module mul_product_cache
  import mult_types::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     lk_rs1_i,
  input  logic [width_p-1:0]     lk_rs2_i,
  input  logic [2:0]             lk_code_i,
  output logic                   hit_o,
  output logic [width_p-1:0]     hit_data_o,
  input  logic                   wr_en_i,
  input  logic [width_p-1:0]     wr_rs1_i,
  input  logic [width_p-1:0]     wr_rs2_i,
  input  logic [2:0]             wr_code_i,
  input  logic [2*width_p-1:0]   wr_product_i,
  input  logic                   inv_i
);

  logic                 valid_q;
  logic [width_p-1:0]   tag_rs1_q, tag_rs2_q;
  logic [2:0]           tag_code_q;
  logic [2*width_p-1:0] product_q;
  logic                 lk_lo;

  // The low half is the same for every signedness, so MUL ignores the stored code.
  always_comb begin
    lk_lo      = (lk_code_i == MCODE_LO);
    hit_o      = CACHE_EN && valid_q && (lk_rs1_i == tag_rs1_q) && (lk_rs2_i == tag_rs2_q) &&
                 (lk_lo || (lk_code_i == tag_code_q));
    hit_data_o = sel_half(product_q, lk_lo);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q    <= 1'b0;
      tag_rs1_q  <= '0;
      tag_rs2_q  <= '0;
      tag_code_q <= MCODE_LO;
      product_q  <= '0;
    end else if (inv_i) begin
      valid_q <= 1'b0;
    end else if (wr_en_i) begin
      valid_q    <= 1'b1;
      tag_rs1_q  <= wr_rs1_i;
      tag_rs2_q  <= wr_rs2_i;
      tag_code_q <= wr_code_i;
      product_q  <= wr_product_i;
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// RV32M multiply issue/retire stage between EX and the shift-add multiplier; a MULH*+MUL pair
// on identical operands issues to the multiplier only once.
module mul_issue_ctrl
  import mult_types::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           funct3_i,
  input  logic [width_p-1:0]   rs1_i,
  input  logic [width_p-1:0]   rs2_i,
  input  logic [4:0]           rd_i,
  input  logic                 flush_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [width_p-1:0]   resp_data_o,
  output logic [4:0]           resp_rd_o,
  output logic                 busy_o,
  output logic                 mul_reset_n_o,
  output logic                 mul_start_o,
  output logic [2:0]           mul_funct3_o,
  output logic [width_p-1:0]   mul_multiplicand_o,
  output logic [width_p-1:0]   mul_multiplier_o,
  input  logic                 mul_ready_i,
  input  logic                 mul_done_i,
  input  logic [2*width_p-1:0] mul_product_i
);

  mic_state_e         state_q;
  mul_op_e            op_q, req_op;
  logic [2:0]         code_q, req_code;
  logic [width_p-1:0] rs1_q, rs2_q, resp_data_q, cache_data;
  logic [4:0]         rd_q;
  logic               accept, cache_hit, cache_wr;

  always_comb begin
    req_op   = decode_op(funct3_i);
    req_code = op_code(req_op);
  end

  assign req_ready_o = (state_q == IDLE);
  assign accept      = req_valid_i & req_ready_o & ~flush_i;
  // A flush in the same cycle as done discards the product entirely.
  assign cache_wr    = (state_q == BUSY) & mul_done_i & ~flush_i;

  mul_product_cache #(
    .CACHE_EN (CACHE_EN)
  ) u_cache (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .lk_rs1_i     (rs1_i),
    .lk_rs2_i     (rs2_i),
    .lk_code_i    (req_code),
    .hit_o        (cache_hit),
    .hit_data_o   (cache_data),
    .wr_en_i      (cache_wr),
    .wr_rs1_i     (rs1_q),
    .wr_rs2_i     (rs2_q),
    .wr_code_i    (code_q),
    .wr_product_i (mul_product_i),
    .inv_i        (state_q == ABORT)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      op_q        <= OP_MUL;
      code_q      <= MCODE_LO;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      resp_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q   <= req_op;
            code_q <= req_code;
            rs1_q  <= rs1_i;
            rs2_q  <= rs2_i;
            rd_q   <= rd_i;
            if (cache_hit) begin
              resp_data_q <= cache_data;
              state_q     <= RESP;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (flush_i)          state_q <= IDLE;
          else if (mul_ready_i) state_q <= BUSY;
        end
        BUSY: begin
          if (flush_i) begin
            state_q <= ABORT;
          end else if (mul_done_i) begin
            resp_data_q <= sel_half(mul_product_i, op_q == OP_MUL);
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (flush_i || resp_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid_o       = (state_q == RESP);
  assign resp_data_o        = resp_data_q;
  assign resp_rd_o          = rd_q;
  assign busy_o             = (state_q != IDLE);
  assign mul_start_o        = (state_q == ISSUE) & mul_ready_i & ~flush_i;
  assign mul_reset_n_o      = ~reset_i & (state_q != ABORT);
  assign mul_funct3_o       = code_q;
  assign mul_multiplicand_o = rs1_q;
  assign mul_multiplier_o   = rs2_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a small shift-add multiplier stand-in.
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        busy, mul_reset_n, mul_start;
  logic [2:0]  mul_funct3;
  logic [31:0] mul_a, mul_b;
  logic        mul_ready, mul_done;
  logic [63:0] mul_product;

  int checks = 0, failures = 0;
  int start_cnt = 0;
  bit ready_en = 1'b1;
  int m_cnt = 0;
  logic m_done = 1'b0;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.CACHE_EN(1'b1)) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .funct3_i           (funct3),
    .rs1_i              (rs1),
    .rs2_i              (rs2),
    .rd_i               (rd_in),
    .flush_i            (flush),
    .resp_valid_o       (resp_valid),
    .resp_ready_i       (resp_ready),
    .resp_data_o        (resp_data),
    .resp_rd_o          (resp_rd),
    .busy_o             (busy),
    .mul_reset_n_o      (mul_reset_n),
    .mul_start_o        (mul_start),
    .mul_funct3_o       (mul_funct3),
    .mul_multiplicand_o (mul_a),
    .mul_multiplier_o   (mul_b),
    .mul_ready_i        (mul_ready),
    .mul_done_i         (mul_done),
    .mul_product_i      (mul_product)
  );

  function automatic logic [63:0] model_prod(input logic [2:0] code, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = (code == 3'b010) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = (code == 3'b001 || code == 3'b000) ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Multiplier stand-in: done pulses three cycles after start.
  assign mul_ready = ready_en && (m_cnt == 0) && !m_done;
  assign mul_done  = m_done;
  always @(posedge clk) begin
    if (mul_start) start_cnt <= start_cnt + 1;
    if (!mul_reset_n) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else if (mul_start) begin
      m_cnt       <= 3;
      m_done      <= 1'b0;
      mul_product <= model_prod(mul_funct3, mul_a, mul_b);
    end else if (m_cnt == 1) begin
      m_cnt  <= 0;
      m_done <= 1'b1;
    end else begin
      m_done <= 1'b0;
      if (m_cnt > 0) m_cnt <= m_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one request and returns at the first negedge after the accepting edge.
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    @(negedge clk);
    req_valid = 1'b1;
    funct3    = f3;
    rs1       = a;
    rs2       = b;
    rd_in     = rd;
    check("req_ready_before_accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic finish_req(input string tag, input int hold, input logic [31:0] exp_data,
                            input logic [4:0] exp_rd, input int exp_lat);
    int lat = 0;
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      if (resp_valid) lat = i;
      else @(negedge clk);
    end
    check({tag, "_resp_seen"}, lat != 0, 1);
    if (exp_lat != 0) check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"}, resp_data, exp_data);
    check({tag, "_rd"}, resp_rd, exp_rd);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, resp_valid, 1);
      check({tag, "_hold_data"}, resp_data, exp_data);
      check({tag, "_hold_rd"}, resp_rd, exp_rd);
      check({tag, "_hold_req_ready"}, req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_valid_after_hs"}, resp_valid, 0);
    check({tag, "_req_ready_after_hs"}, req_ready, 1);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  code;
    bit          hit;
  } vec_t;

  vec_t vecs[12];
  int   s0;

  initial begin
    vecs[0]  = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 5'd1,  32'h0000_0001, 3'b010, 1'b0};
    vecs[1]  = '{3'b001, 32'hFFFF_FFF1, 32'h0000_000F, 5'd2,  32'hFFFF_FFFF, 3'b001, 1'b0};
    vecs[2]  = '{3'b000, 32'hFFFF_FFF1, 32'h0000_000F, 5'd3,  32'hFFFF_FF1F, 3'b000, 1'b1};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h8000_0000, 5'd4,  32'hFFFF_FFFF, 3'b011, 1'b0};
    vecs[4]  = '{3'b011, 32'hFFFF_FFFF, 32'h8000_0000, 5'd5,  32'h7FFF_FFFF, 3'b010, 1'b0};
    vecs[5]  = '{3'b000, 32'h0000_0003, 32'h0000_0005, 5'd6,  32'h0000_000F, 3'b000, 1'b0};
    vecs[6]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000, 3'b001, 1'b0};
    vecs[7]  = '{3'b011, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'h4000_0000, 3'b010, 1'b0};
    vecs[8]  = '{3'b010, 32'h8000_0000, 32'h8000_0000, 5'd9,  32'hC000_0000, 3'b011, 1'b0};
    vecs[9]  = '{3'b000, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h0000_0000, 3'b000, 1'b1};
    vecs[10] = '{3'b010, 32'h8000_0000, 32'h8000_0000, 5'd11, 32'hC000_0000, 3'b011, 1'b1};
    vecs[11] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd12, 32'h4000_0000, 3'b001, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mul_reset_n", mul_reset_n, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_funct3", mul_funct3, 0);
    check("rst_resp_data", resp_data, 0);
    reset = 1'b0;
    #1;
    check("post_rst_mul_reset_n", mul_reset_n, 1);

    foreach (vecs[i]) begin
      s0 = start_cnt;
      send(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd);
      check($sformatf("v%0d_mul_funct3", i), mul_funct3, vecs[i].code);
      finish_req($sformatf("v%0d", i), 0, vecs[i].data, vecs[i].rd, vecs[i].hit ? 1 : 0);
      check($sformatf("v%0d_starts", i), start_cnt - s0, vecs[i].hit ? 0 : 1);
    end

    // Multiplier not ready for five cycles
    ready_en = 1'b0;
    s0 = start_cnt;
    send(3'b000, 32'd7, 32'd6, 5'd13);
    for (int i = 0; i < 5; i++) begin
      check("nrdy_start_low", mul_start, 0);
      check("nrdy_busy", busy, 1);
      @(negedge clk);
    end
    ready_en = 1'b1;
    #1;
    check("nrdy_start_on_ready", mul_start, 1);
    finish_req("nrdy", 0, 32'd42, 5'd13, 0);
    check("nrdy_starts", start_cnt - s0, 1);

    // Flush while the multiplier is busy
    send(3'b001, 32'd9, 32'd9, 5'd14);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_abort_reset_n", mul_reset_n, 0);
    check("flush_abort_valid", resp_valid, 0);
    @(negedge clk);
    check("flush_reset_n_back", mul_reset_n, 1);
    check("flush_idle_ready", req_ready, 1);
    s0 = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) s0++;
      @(negedge clk);
    end
    check("flush_no_resp", s0, 0);
    s0 = start_cnt;
    send(3'b000, 32'd9, 32'd9, 5'd16);
    finish_req("post_flush", 0, 32'd81, 5'd16, 0);
    check("post_flush_starts", start_cnt - s0, 1);

    // Writeback stalls for four cycles
    send(3'b000, 32'h10, 32'h10, 5'd15);
    finish_req("hold", 4, 32'h100, 5'd15, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
